uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Adds configurable data width, parity, stop-bit count and an internal transmit FIFO, so producers can queue several bytes and frames go out back-to-back with no idle gap. Sits between a byte producer (command/report logic) and the board TX pin; the output line format matches the existing receiver family.

## Interface
- CLK_FREQ, 50000000: system clock frequency, Hz
- UART_BPS, 9600: baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division), must be >= 2
- DATA_BITS, 8: data bits per frame, legal 5..9
- PARITY, 0: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1: 1 or 2
- FIFO_DEPTH, 16: transmit FIFO entries, power of two, >= 2
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- uart_tx_en  input  1  write strobe, one word per cycle while high
- uart_tx_data  input  DATA_BITS  word to queue, sampled with uart_tx_en
- uart_tx_full  output  1  FIFO full; writes while high are dropped
- uart_tx_level  output  $clog2(FIFO_DEPTH)+1  words queued (excludes frame in flight)
- uart_tx_busy  output  1  high while a frame is on the line or FIFO non-empty
- uart_tx_done  output  1  one-cycle pulse in the last cycle of each frame's final stop bit
- uart_txd  output  1  serial line, idle high

## Operation
- Reset (rst high at a clock edge): FIFO emptied, FSM to IDLE, uart_txd=1, uart_tx_busy=0, uart_tx_done=0, uart_tx_full=0, uart_tx_level=0. Reset mid-frame aborts the frame; line returns high the cycle after.
- Write: uart_tx_en=1 and uart_tx_full=0 at an edge stores uart_tx_data. uart_tx_en with full=1 is ignored, FIFO contents unchanged, no error flag.
- Simultaneous write and pop in one cycle: both happen, level unchanged. Full flag is the registered value; a write in the same cycle a pop frees the full FIFO is still dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO non-empty, pop head into shift register, go START.
- START: txd=0 for BAUD_CNT_MAX cycles, then DATA with bit index 0.
- DATA: txd = bit[index], LSB first, each BAUD_CNT_MAX cycles; after index DATA_BITS-1 go PARITY if PARITY!=0 else STOP.
- PARITY: txd = XOR of data bits (even) or its inverse (odd), one bit time.
- STOP: txd=1 for STOP_BITS bit times. In the final cycle assert uart_tx_done; if FIFO non-empty pop and go START directly (no idle bit), else IDLE.
- Baud counter: 0..BAUD_CNT_MAX-1, cleared on every state entry from IDLE; bit boundaries at count BAUD_CNT_MAX-1.
- Data bits above DATA_BITS do not exist; uart_tx_data width follows DATA_BITS exactly.

## Timing
- uart_txd is a registered output, no combinational path from any input.
- Write at edge N into empty FIFO with FSM IDLE: pop at edge N+1, uart_txd falls after edge N+1 (one-cycle latency from write to start bit).
- Frame length F = BAUD_CNT_MAX*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, exact, no jitter between frames.
- Back-to-back frames: start bit of frame k+1 begins the cycle after frame k's done pulse.
- uart_tx_level, uart_tx_full update the cycle after the causing write/pop edge.
- uart_tx_busy falls the cycle after the final done pulse when FIFO is empty.

## Test plan
- Defaults except UART_BPS=5000000 (BAUD_CNT_MAX=10), 8N1: write 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 10 cycles, start bit one cycle after write, done pulse at cycle 100 of frame, busy drops next cycle.
- DATA_BITS=7, PARITY=2, STOP_BITS=2: write 0x43 -> bits 0,1100001(LSB first),parity 1,1,1; frame 110 cycles; repeat PARITY=1 -> parity bit 0.
- FIFO_DEPTH=4: write 0xA0..0xA5 on six consecutive cycles -> first pops immediately, four queued, full asserted, 0xA5 dropped; five frames back-to-back with no idle bit, level counts 4,3,2,1,0 at each pop.
- Write in the same cycle as a pop with FIFO full -> write dropped, level stays FIFO_DEPTH-1 next cycle.
- Assert rst mid data bit 3 of frame with 2 words queued -> txd=1, busy=0, level=0, full=0 the cycle after; no done pulse; next write transmits cleanly.
- DATA_BITS=9, PARITY=0: write 9'h1FF -> start, nine 1 bits, stop; frame 110 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter (DATA_BITS, parity, 1/2 stop) fed by an internal FIFO.
// Latency: a write into an empty FIFO with the line idle starts the start bit one cycle later; frames run back-to-back.
// Backpressure: uart_tx_full (registered) high -> writes are silently dropped; the line itself never stalls.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   uart_tx_en/data   write strobe and DATA_BITS-wide word to queue
//   uart_tx_full      FIFO full (registered), writes dropped while high
//   uart_tx_level     words waiting in the FIFO (frame in flight not counted)
//   uart_tx_busy      frame on the line or FIFO non-empty
//   uart_tx_done      one-cycle pulse in the last cycle of each frame's final stop bit
//   uart_txd          registered serial line, idle high

// sync_fifo: generic single-clock FIFO with registered full flag and occupancy count.
// Latency: written word is visible at the read side the cycle after the write edge.
// Backpressure: wr_rdy is the registered not-full flag; a slot freed by a pop is usable one cycle later.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             push, pop;

    always_comb begin
        // Full is judged on the registered flag, so a pop in the same cycle
        // does not make room for a concurrent write.
        push     = wr_vld && !full_q;
        pop      = rd_rdy && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: only slots covered by count_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

    assign wr_rdy = !full_q;
    assign rd_vld = (count_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign level  = count_q;
endmodule

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_tx_en,
    input  logic [DATA_BITS-1:0]          uart_tx_data,
    output logic                          uart_tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   uart_tx_level,
    output logic                          uart_tx_busy,
    output logic                          uart_tx_done,
    output logic                          uart_txd
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [BW-1:0] LAST_IDX  = BW'(DATA_BITS - 1);
    localparam logic USE_PAR  = (PARITY != 0);
    localparam logic ODD_PAR  = (PARITY == 1);
    localparam logic TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;

    logic                 fifo_rd_vld;
    logic                 fifo_wr_rdy;
    logic [DATA_BITS-1:0] fifo_rd_dat;
    logic                 pop;
    logic                 bit_end;
    logic                 par_bit;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (uart_tx_en),
        .wr_dat (uart_tx_data),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (pop),
        .rd_dat (fifo_rd_dat),
        .level  (uart_tx_level)
    );

    // Next-state logic. The line and done outputs are registered, so they
    // are computed from the *next* state: whatever bit the FSM is entering
    // is what the line shows in the following cycle.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        pop        = 1'b0;
        bit_end    = (baud_cnt_q == BAUD_LAST);

        // Free-running modulo counter while a frame is active; wrapping at
        // each bit boundary also clears it on a STOP->START chain.
        if (state_q != S_IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                if (fifo_rd_vld) begin
                    pop     = 1'b1;
                    data_d  = fifo_rd_dat;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d    = USE_PAR ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == TWO_STOP) begin
                        // Chain straight into the next start bit when more
                        // data is waiting, so there is no idle gap.
                        if (fifo_rd_vld) begin
                            pop     = 1'b1;
                            data_d  = fifo_rd_dat;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        par_bit = (^data_d) ^ ODD_PAR;

        unique case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = data_d[bit_idx_d];
            S_PARITY: txd_d = par_bit;
            default:  txd_d = 1'b1;
        endcase

        // Done marks the last cycle of the final stop bit.
        done_d = (state_d == S_STOP) && (stop_cnt_d == TWO_STOP) &&
                 (baud_cnt_d == BAUD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_done = done_q;
    assign uart_tx_full = !fifo_wr_rdy;
    assign uart_tx_busy = (state_q != S_IDLE) || fifo_rd_vld;
endmodule
